// File: rtl/adc_spi_responder.sv
// Responder end of the 4-wire ADC serial link: captures a config word on adc_din and
// returns the previously selected channel's sample on adc_dout (config pipelined one frame).
module adc_spi_responder #(
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned CFG_BITS    = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] ch0,
  input  logic [DATA_BITS-1:0] ch1,
  input  logic [DATA_BITS-1:0] ch2,
  input  logic [DATA_BITS-1:0] ch3,
  input  logic [DATA_BITS-1:0] ch4,
  input  logic [DATA_BITS-1:0] ch5,
  input  logic [DATA_BITS-1:0] ch6,
  input  logic [DATA_BITS-1:0] ch7,
  input  logic                 adc_sclk,
  input  logic                 adc_cs_n,
  input  logic                 adc_din,
  output logic                 adc_dout,
  output logic [CFG_BITS-1:0]  cfg_word,
  output logic [2:0]           active_ch,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam int unsigned       CNT_W     = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CFG_CNT   = CNT_W'(CFG_BITS);
  localparam logic [CFG_BITS-1:0] CFG_RESET = CFG_BITS'(6'b100010);

  typedef enum logic [1:0] {IDLE, SHIFT, CLOSE} state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, din_sync;
  logic                  sclk_q, cs_q;
  logic [DATA_BITS-1:0]  shift_q, shift_d, ch_sel;
  logic [CFG_BITS-1:0]   cfg_rx_q, cfg_rx_d, cfg_word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_rise_q, pend_rise_d, pend_fall_q, pend_fall_d;
  logic [2:0]            active_d;
  logic                  dout_d, done_d, err_d;
  logic                  sclk_s, cs_s, din_s;
  logic                  sclk_rise, sclk_fall, cs_fall, cs_rise, rise, fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  // Input synchronisers; cs_n resets high so reset release never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      din_sync  <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], adc_din};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  always_comb begin
    ch_sel = ch0;
    case (active_ch)
      3'd0:    ch_sel = ch0;
      3'd1:    ch_sel = ch1;
      3'd2:    ch_sel = ch2;
      3'd3:    ch_sel = ch3;
      3'd4:    ch_sel = ch4;
      3'd5:    ch_sel = ch5;
      3'd6:    ch_sel = ch6;
      default: ch_sel = ch7;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cfg_rx_q    <= '0;
      cnt_q       <= '0;
      pend_rise_q <= 1'b0;
      pend_fall_q <= 1'b0;
      adc_dout    <= 1'b0;
      cfg_word    <= CFG_RESET;
      active_ch   <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cfg_rx_q    <= cfg_rx_d;
      cnt_q       <= cnt_d;
      pend_rise_q <= pend_rise_d;
      pend_fall_q <= pend_fall_d;
      adc_dout    <= dout_d;
      cfg_word    <= cfg_word_d;
      active_ch   <= active_d;
      frame_done  <= done_d;
      frame_err   <= err_d;
    end
  end

  // Frame FSM; an SCLK edge coinciding with the frame load is deferred one cycle
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cfg_rx_d    = cfg_rx_q;
    cnt_d       = cnt_q;
    pend_rise_d = 1'b0;
    pend_fall_d = 1'b0;
    cfg_word_d  = cfg_word;
    active_d    = active_ch;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rise        = sclk_rise | pend_rise_q;
    fall        = sclk_fall | pend_fall_q;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shift_d     = ch_sel;
          cfg_rx_d    = '0;
          cnt_d       = '0;
          pend_rise_d = sclk_rise;
          pend_fall_d = sclk_fall;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = CLOSE;
        end else begin
          if (rise) begin
            if (cnt_q < CFG_CNT) cfg_rx_d = {cfg_rx_q[CFG_BITS-2:0], din_s};
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          end
          if (fall) shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
        end
      end
      CLOSE: begin
        state_d = IDLE;
        if (cnt_q >= CFG_CNT) begin
          cfg_word_d = cfg_rx_q;
          // {O/S,S1,S0} -> channel {S1,S0,O/S}
          active_d   = {cfg_rx_q[CFG_BITS-3], cfg_rx_q[CFG_BITS-4], cfg_rx_q[CFG_BITS-2]};
          done_d     = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    dout_d = (state_d == SHIFT) ? shift_d[DATA_BITS-1] : 1'b0;
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: vector table of frames plus hand-written
// sequences for coincident CS/SCLK edges and mid-frame reset.
module tb_adc_spi_responder;

  localparam int HALF = 6;
  localparam int NV   = 14;

  typedef struct {
    logic [5:0]  din;
    int          nclk;
    int          set_idx;
    logic [11:0] set_val;
    logic [15:0] exp_rx;
    logic        exp_done;
    logic        exp_err;
    logic [5:0]  exp_cfg;
    logic [2:0]  exp_ch;
  } vec_t;

  logic        clk, rst_n, sclk, cs_n, din;
  logic [11:0] chv [8];
  logic        adc_dout, frame_done, frame_err;
  logic [5:0]  cfg_word;
  logic [2:0]  active_ch;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_total = 0;
  int   err_total = 0;
  int   nv = 0;
  vec_t vecs [NV];
  vec_t exp_q [$];

  adc_spi_responder dut (
    .clk(clk), .rst_n(rst_n),
    .ch0(chv[0]), .ch1(chv[1]), .ch2(chv[2]), .ch3(chv[3]),
    .ch4(chv[4]), .ch5(chv[5]), .ch6(chv[6]), .ch7(chv[7]),
    .adc_sclk(sclk), .adc_cs_n(cs_n), .adc_din(din), .adc_dout(adc_dout),
    .cfg_word(cfg_word), .active_ch(active_ch),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) done_total++;
      if (frame_err)  err_total++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] map_ch(input logic [2:0] code);
    case (code)
      3'b000:  return 3'd0;
      3'b100:  return 3'd1;
      3'b001:  return 3'd2;
      3'b101:  return 3'd3;
      3'b010:  return 3'd4;
      3'b110:  return 3'd5;
      3'b011:  return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic add(input logic [5:0] d, input int n, input int idx, input logic [11:0] v);
    vecs[nv].din     = d;
    vecs[nv].nclk    = n;
    vecs[nv].set_idx = idx;
    vecs[nv].set_val = v;
    nv++;
  endtask

  // Master-side frame: DIN changes on SCLK fall, DOUT sampled just before each rise
  task automatic run_frame(input logic [5:0] cfg, input int nclk, output logic [15:0] rx);
    rx = '0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < nclk; i++) begin
      din = (i < 6) ? cfg[5-i] : 1'b1;
      tick(HALF);
      rx = {rx[14:0], adc_dout};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    cs_n = 1'b1;
    din  = 1'b0;
    tick(8);
  endtask

  task automatic frame_checks(input string tag, input logic [15:0] rx, input int d0, input int e0,
                              input vec_t e);
    check({tag, " dout"},   32'(rx), 32'(e.exp_rx));
    check({tag, " done"},   32'(done_total - d0), 32'(e.exp_done));
    check({tag, " err"},    32'(err_total - e0), 32'(e.exp_err));
    check({tag, " cfg"},    32'(cfg_word), 32'(e.exp_cfg));
    check({tag, " ch"},     32'(active_ch), 32'(e.exp_ch));
  endtask

  initial begin
    logic [15:0] rx;
    logic [11:0] m_vals [8];
    logic [5:0]  m_cfg;
    logic [2:0]  m_ch;
    logic [15:0] full;
    logic [5:0]  cw;
    vec_t        e;
    int          d0, e0;

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; din = 1'b0;
    for (int n = 0; n < 8; n++) chv[n] = 12'(12'h100 + n);

    // Frame table: config word, SCLK count, channel written before the frame
    add(6'b100010, 12, 0,  12'hABC);
    add(6'b110100, 12, 3,  12'h5A5);
    add(6'b111000, 12, -1, 12'h000);
    add(6'b000000, 12, 0,  12'h100);
    add(6'b110001, 12, 3,  12'h103);
    add(6'b000110, 12, -1, 12'h000);
    add(6'b110111, 12, -1, 12'h000);
    add(6'b001000, 12, -1, 12'h000);
    add(6'b011001, 12, -1, 12'h000);
    add(6'b101110, 12, -1, 12'h000);
    add(6'b011111, 12, -1, 12'h000);
    add(6'b000000, 4,  -1, 12'h000);
    add(6'b000011, 12, -1, 12'h000);
    add(6'b000011, 16, 0,  12'hFFF);

    // Reference model: data from the channel chosen by the previous accepted frame
    for (int n = 0; n < 8; n++) m_vals[n] = 12'(12'h100 + n);
    m_cfg = 6'b100010;
    m_ch  = 3'd0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].set_idx >= 0) m_vals[vecs[i].set_idx] = vecs[i].set_val;
      full = {m_vals[m_ch], 4'h0};
      vecs[i].exp_rx = full >> (16 - vecs[i].nclk);
      if (vecs[i].nclk >= 6) begin
        m_cfg = vecs[i].din;
        m_ch  = map_ch(vecs[i].din[4:2]);
        vecs[i].exp_done = 1'b1;
        vecs[i].exp_err  = 1'b0;
      end else begin
        vecs[i].exp_done = 1'b0;
        vecs[i].exp_err  = 1'b1;
      end
      vecs[i].exp_cfg = m_cfg;
      vecs[i].exp_ch  = m_ch;
    end

    tick(3);
    check("rst dout", 32'(adc_dout), 32'd0);
    check("rst cfg",  32'(cfg_word), 32'h22);
    check("rst ch",   32'(active_ch), 32'd0);
    check("rst done", 32'(frame_done), 32'd0);
    check("rst err",  32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].set_idx >= 0) chv[vecs[i].set_idx] = vecs[i].set_val;
      exp_q.push_back(vecs[i]);
      d0 = done_total;
      e0 = err_total;
      run_frame(vecs[i].din, vecs[i].nclk, rx);
      if (exp_q.size() == 0) begin
        check("scoreboard empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        frame_checks($sformatf("vec%0d", i), rx, d0, e0, e);
      end
    end

    // CS_N fall together with the first SCLK rise: that rise must still count
    cw = 6'b001110;
    d0 = done_total; e0 = err_total;
    @(negedge clk);
    cs_n = 1'b0; sclk = 1'b1; din = cw[5];
    tick(HALF);
    sclk = 1'b0;
    for (int i = 1; i < 6; i++) begin
      din = cw[5-i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    cs_n = 1'b1; din = 1'b0;
    tick(8);
    check("coinc done", 32'(done_total - d0), 32'd1);
    check("coinc err",  32'(err_total - e0), 32'd0);
    check("coinc cfg",  32'(cfg_word), 32'(cw));
    check("coinc ch",   32'(active_ch), 32'd6);

    // Follow-up frame returns CH6 and selects CH1
    d0 = done_total;
    run_frame(6'b010000, 12, rx);
    check("post dout", 32'(rx), 32'h106);
    check("post done", 32'(done_total - d0), 32'd1);
    check("post ch",   32'(active_ch), 32'd1);

    // Reset after the 5th SCLK with CH1 active and DOUT high
    chv[1] = 12'hFFF;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 1'b0;
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    check("pre-rst dout", 32'(adc_dout), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-rst dout", 32'(adc_dout), 32'd0);
    check("mid-rst cfg",  32'(cfg_word), 32'h22);
    check("mid-rst ch",   32'(active_ch), 32'd0);
    cs_n = 1'b1; sclk = 1'b0; din = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chv[0] = 12'hABC;
    d0 = done_total; e0 = err_total;
    run_frame(6'b100010, 12, rx);
    check("after-rst dout", 32'(rx), 32'hABC);
    check("after-rst done", 32'(done_total - d0), 32'd1);
    check("after-rst err",  32'(err_total - e0), 32'd0);
    check("after-rst ch",   32'(active_ch), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
